// File: rtl/servo_pkg.sv
// servo_pkg: default 50 MHz servo timing constants and position-to-width mapping.
package servo_pkg;
  localparam int PERIOD_CYC_DEF = 1_000_000;
  localparam int MIN_CYC_DEF    = 50_000;
  localparam int RES_CYC_DEF    = 800;
  localparam int MAX_CYC_DEF    = 250_000;
  localparam int SLEW_CYC_DEF   = 1_000;
  // Evaluated at 32 bits so the product cannot wrap before the clamp.
  function automatic int unsigned pos_to_width(input int unsigned pos, input int unsigned min_c,
                                               input int unsigned res_c, input int unsigned max_c);
    return (min_c + pos * res_c > max_c) ? max_c : min_c + pos * res_c;
  endfunction
endpackage

// File: rtl/servo_ramp_ch.sv
// servo_ramp_ch: per-channel target/current width, frame-rate slew, PWM compare and busy flag.
module servo_ramp_ch
  import servo_pkg::*;
#(
  parameter int POS_W    = 8,
  parameter int CNT_W    = 21,
  parameter int MIN_CYC  = MIN_CYC_DEF,
  parameter int RES_CYC  = RES_CYC_DEF,
  parameter int MAX_CYC  = MAX_CYC_DEF,
  parameter int SLEW_CYC = SLEW_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt,
  input  logic             fe,
  input  logic             en_q,
  input  logic [POS_W-1:0] pos_i,
  input  logic             pos_valid_i,
  output logic             servo,
  output logic             busy
);
  localparam logic [CNT_W-1:0] MIN_W  = CNT_W'(MIN_CYC);
  localparam logic [CNT_W-1:0] SLEW_W = CNT_W'(SLEW_CYC);
  logic [CNT_W-1:0] tgt_w, cur_w, nxt_w, up, dn;
  always_comb begin
    up    = tgt_w - cur_w;
    dn    = cur_w - tgt_w;
    nxt_w = (SLEW_CYC == 0) ? tgt_w :
            (tgt_w > cur_w) ? ((up > SLEW_W) ? cur_w + SLEW_W : tgt_w) :
                              ((dn > SLEW_W) ? cur_w - SLEW_W : tgt_w);
  end
  // cur_w moves only at frame end, so a pulse in flight is never reshaped.
  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_w <= MIN_W;
      cur_w <= MIN_W;
      servo <= 1'b0;
      busy  <= 1'b0;
    end else begin
      if (pos_valid_i) tgt_w <= CNT_W'(pos_to_width(32'(pos_i), MIN_CYC, RES_CYC, MAX_CYC));
      if (fe) cur_w <= nxt_w;
      servo <= en_q && (cnt < cur_w);
      busy  <= cur_w != tgt_w;
    end
  end
endmodule

// File: rtl/servo_pwm_ramp.sv
// servo_pwm_ramp: N-channel servo PWM with shared frame counter and slew-limited widths.
module servo_pwm_ramp
  import servo_pkg::*;
#(
  parameter int N_CH       = 3,
  parameter int POS_W      = 8,
  parameter int CNT_W      = 21,
  parameter int PERIOD_CYC = PERIOD_CYC_DEF,
  parameter int MIN_CYC    = MIN_CYC_DEF,
  parameter int RES_CYC    = RES_CYC_DEF,
  parameter int MAX_CYC    = MAX_CYC_DEF,
  parameter int SLEW_CYC   = SLEW_CYC_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [N_CH*POS_W-1:0] pos,
  input  logic [N_CH-1:0]       pos_valid,
  output logic [N_CH-1:0]       servo,
  output logic                  frame_start,
  output logic [N_CH-1:0]       busy
);
  if (MAX_CYC >= PERIOD_CYC || MIN_CYC > MAX_CYC ||
      longint'(PERIOD_CYC) > (longint'(1) << CNT_W)) begin : g_bad_params
    $error("servo_pwm_ramp: illegal timing parameters");
  end
  logic [CNT_W-1:0] cnt;
  logic             fe, en_q;
  assign fe = cnt == CNT_W'(PERIOD_CYC - 1);
  // en is only sampled at frame end so enabling/disabling never produces runt pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      en_q        <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      cnt         <= fe ? '0 : cnt + 1'b1;
      en_q        <= fe ? en : en_q;
      frame_start <= cnt == '0;
    end
  end
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    servo_ramp_ch #(
      .POS_W(POS_W), .CNT_W(CNT_W), .MIN_CYC(MIN_CYC),
      .RES_CYC(RES_CYC), .MAX_CYC(MAX_CYC), .SLEW_CYC(SLEW_CYC)
    ) u_ch (
      .clk(clk), .rst(rst), .cnt(cnt), .fe(fe), .en_q(en_q),
      .pos_i(pos[i*POS_W +: POS_W]), .pos_valid_i(pos_valid[i]),
      .servo(servo[i]), .busy(busy[i])
    );
  end
endmodule

// File: tb/tb_servo_pwm_ramp.sv
// tb_servo_pwm_ramp: frame-level reference model driving a jump (SLEW=0) and a ramp (SLEW=4) instance.
module tb_servo_pwm_ramp;
  localparam int N = 3, PW = 8, CW = 7, PER = 100, MINC = 10, RES = 2, MAXC = 50;
  logic clk = 1'b0, rst = 1'b1, en = 1'b1;
  logic [N*PW-1:0] pos = '0;
  logic [N-1:0] pos_valid = '0;
  logic [N-1:0] servo0, servo4, busy0, busy4;
  logic fs0, fs4;
  int checks = 0, failures = 0;
  int tgt[N];
  int cur[2][N];
  bit enq, en_lvl;
  always #5 clk = ~clk;
  servo_pwm_ramp #(.N_CH(N), .POS_W(PW), .CNT_W(CW), .PERIOD_CYC(PER), .MIN_CYC(MINC),
                   .RES_CYC(RES), .MAX_CYC(MAXC), .SLEW_CYC(0)) u0 (
    .clk(clk), .rst(rst), .en(en), .pos(pos), .pos_valid(pos_valid),
    .servo(servo0), .frame_start(fs0), .busy(busy0));
  servo_pwm_ramp #(.N_CH(N), .POS_W(PW), .CNT_W(CW), .PERIOD_CYC(PER), .MIN_CYC(MINC),
                   .RES_CYC(RES), .MAX_CYC(MAXC), .SLEW_CYC(4)) u4 (
    .clk(clk), .rst(rst), .en(en), .pos(pos), .pos_valid(pos_valid),
    .servo(servo4), .frame_start(fs4), .busy(busy4));

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int p2w(input int p);
    return (MINC + p * RES > MAXC) ? MAXC : MINC + p * RES;
  endfunction

  function automatic int slew(input int c, input int t, input int s);
    if (s == 0) return t;
    if (t - c > s) return c + s;
    if (c - t > s) return c - s;
    return t;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < N; c++) begin
      tgt[c] = MINC;
      cur[0][c] = MINC;
      cur[1][c] = MINC;
    end
    enq = 1'b0;
  endfunction

  // One frame, from frame_start, with an optional input action during cycle act_k (cnt = act_k+1).
  task automatic run_frame(input string tag, input int act_k, input logic [2:0] pv,
                           input int p0, input int p1, input int p2, input bit e);
    int n = 0, fsn0 = 0, fsn4 = 0;
    int hc[2][N];
    int fl[2][N];
    int ps[N];
    logic [N-1:0] sv[2];
    ps = '{p0, p1, p2};
    do begin @(negedge clk); n++; end while (!fs0 && n < 300);
    if (!fs0) begin
      $display("FAIL %s frame_start_timeout observed=0 expected=1", tag);
      $fatal(1);
    end
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < N; c++) begin hc[d][c] = 0; fl[d][c] = PER; end
    for (int k = 0; k < PER; k++) begin
      if (k > 0) @(negedge clk);
      fsn0 += int'(fs0);
      fsn4 += int'(fs4);
      sv[0] = servo0;
      sv[1] = servo4;
      for (int d = 0; d < 2; d++)
        for (int c = 0; c < N; c++) begin
          if (sv[d][c]) hc[d][c]++;
          else if (fl[d][c] == PER) fl[d][c] = k;
        end
      if (k == 0)
        for (int c = 0; c < N; c++) begin
          check({tag, "_busy0"}, int'(busy0[c]), int'(cur[0][c] != tgt[c]));
          check({tag, "_busy4"}, int'(busy4[c]), int'(cur[1][c] != tgt[c]));
        end
      if (k == act_k) begin
        for (int c = 0; c < N; c++) pos[c*PW +: PW] = PW'(ps[c]);
        pos_valid = pv;
        en = e;
      end else if (k == act_k + 1) pos_valid = '0;
    end
    pos_valid = '0;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < N; c++) begin
        check($sformatf("%s_width_d%0d_ch%0d", tag, d, c), hc[d][c], enq ? cur[d][c] : 0);
        check($sformatf("%s_rise_d%0d_ch%0d", tag, d, c), fl[d][c], enq ? cur[d][c] : 0);
      end
    check({tag, "_fs0"}, fsn0, 1);
    check({tag, "_fs4"}, fsn4, 1);
    if (act_k >= 0 && act_k < 98)
      for (int c = 0; c < N; c++) if (pv[c]) tgt[c] = p2w(ps[c]);
    if (act_k >= 0) en_lvl = e;
    for (int c = 0; c < N; c++) begin
      cur[0][c] = slew(cur[0][c], tgt[c], 0);
      cur[1][c] = slew(cur[1][c], tgt[c], 4);
    end
    enq = en_lvl;
    if (act_k == 98)
      for (int c = 0; c < N; c++) if (pv[c]) tgt[c] = p2w(ps[c]);
  endtask

  initial begin
    logic [N-1:0] exp_sv;
    model_reset();
    en_lvl = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_servo0", int'(servo0), 0);
    check("rst_servo4", int'(servo4), 0);
    check("rst_fs", int'(fs0), 0);
    check("rst_busy", int'({busy0, busy4}), 0);
    rst = 1'b0;
    run_frame("f0", -1, 3'b000, 0, 0, 0, 1'b1);
    run_frame("f1_ld12", 10, 3'b010, 0, 12, 0, 1'b1);
    run_frame("f2", -1, 3'b000, 0, 0, 0, 1'b1);
    run_frame("f3_midpulse", 4, 3'b101, 10, 0, 255, 1'b1);
    for (int f = 0; f < 10; f++) run_frame("ramp", -1, 3'b000, 0, 0, 0, 1'b1);
    run_frame("fe_load", 98, 3'b011, 0, 20, 0, 1'b1);
    run_frame("fe_keep", -1, 3'b000, 0, 0, 0, 1'b1);
    run_frame("fe_apply", -1, 3'b000, 0, 0, 0, 1'b1);
    run_frame("en_off", 2, 3'b000, 0, 0, 0, 1'b0);
    run_frame("dis1", -1, 3'b000, 0, 0, 0, 1'b0);
    run_frame("en_on", 40, 3'b000, 0, 0, 0, 1'b1);
    run_frame("en_ok", -1, 3'b000, 0, 0, 0, 1'b1);
    for (int f = 0; f < 14; f++)
      run_frame("rand", int'($urandom_range(0, 98)), 3'($urandom),
                int'($urandom_range(0, 25)), int'($urandom_range(0, 25)),
                ($urandom % 5 == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 25)),
                ($urandom % 4) != 0);
    run_frame("pre_rst", 50, 3'b111, 10, 10, 10, 1'b1);
    for (int f = 0; f < 6; f++) run_frame("settle", -1, 3'b000, 0, 0, 0, 1'b1);
    begin
      int n = 0;
      do begin @(negedge clk); n++; end while (!fs0 && n < 300);
      check("mid_rst_fs", int'(fs0), 1);
      repeat (19) @(negedge clk);
      for (int c = 0; c < N; c++) exp_sv[c] = enq && (cur[0][c] > 19);
      check("mid_rst_pre", int'(servo0), int'(exp_sv));
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_servo0", int'(servo0), 0);
      check("mid_rst_servo4", int'(servo4), 0);
      check("mid_rst_busy", int'({busy0, busy4}), 0);
      check("mid_rst_fs0", int'(fs0), 0);
      rst = 1'b0;
      model_reset();
    end
    run_frame("post_rst0", -1, 3'b000, 0, 0, 0, 1'b1);
    run_frame("post_rst1", -1, 3'b000, 0, 0, 0, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
